// File: rtl/ps2_mouse_sequencer_if.sv
// Transceiver-side bus of ps2_mouse_sequencer: command request/handshake plus received-byte strobe.
// master = sequencer, slave = PS/2 transceiver.
interface ps2_mouse_sequencer_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output the_command, send_command,
    input  command_was_sent, error_communication_timed_out, received_data, received_data_en
  );

  modport slave (
    input  the_command, send_command,
    output command_was_sent, error_communication_timed_out, received_data, received_data_en
  );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up sequencer and movement-packet decoder.
// Define PS2_SEQ_INTELLIMOUSE_EN to add the wheel-mode knock sequence and 4-byte packets.
module ps2_mouse_sequencer #(
  parameter logic [7:0] SAMPLE_RATE     = 8'd100,
  parameter int         RESP_TIMEOUT    = 50_000_000,
  parameter int         PKT_GAP_TIMEOUT = 250_000,
  parameter int         MAX_RETRIES     = 3
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  ps2_mouse_sequencer_if.master        ps2,
  output logic                         init_done,
  output logic                         init_error,
  output logic                         packet_valid,
  output logic [2:0]                   buttons,
  output logic [8:0]                   dx,
  output logic [8:0]                   dy,
  output logic [1:0]                   overflow,
  output logic [3:0]                   dz
);
  localparam int TMAX = (RESP_TIMEOUT > PKT_GAP_TIMEOUT) ? RESP_TIMEOUT : PKT_GAP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] RESP_TO   = TW'(RESP_TIMEOUT);
  localparam logic [TW-1:0] GAP_TO    = TW'(PKT_GAP_TIMEOUT);
  localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] R_ONE     = RW'(1);
`ifdef PS2_SEQ_INTELLIMOUSE_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
  localparam logic [3:0] ID_IDX   = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd3;
`endif

  typedef enum logic [2:0] {
    ST_SEND, ST_ACK, ST_BAT_AA, ST_BAT_ID, ST_FAIL, ST_ERROR, ST_STREAM, ST_WAIT_ID
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hFF;
      4'd1:    b = 8'hF3;
      4'd2:    b = SAMPLE_RATE;
`ifdef PS2_SEQ_INTELLIMOUSE_EN
      4'd3:    b = 8'hF3;
      4'd4:    b = 8'hC8;
      4'd5:    b = 8'hF3;
      4'd6:    b = 8'h64;
      4'd7:    b = 8'hF3;
      4'd8:    b = 8'h50;
      4'd9:    b = 8'hF2;
      4'd10:   b = 8'hF4;
`else
      4'd3:    b = 8'hF4;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cmd_idx_q, cmd_idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [6:0]    hdr_q, hdr_d;       // {b0[7:4], b0[2:0]}; bit3 is always 1 once synced
  logic [7:0]    b1_q, b1_d;
`ifdef PS2_SEQ_INTELLIMOUSE_EN
  logic          ims_q, ims_d;
  logic [7:0]    b2_q, b2_d;
`endif
  logic          emit_s;
  logic [7:0]    ylo_s;
  logic [3:0]    zw_s;
  logic [7:0]    rx_s;
  logic          en_s;

  logic [7:0] the_command_q, the_command_d;
  logic       send_command_q, send_command_d;
  logic       init_done_q, init_done_d, init_error_q, init_error_d;
  logic       packet_valid_q, packet_valid_d;
  logic [2:0] buttons_q, buttons_d;
  logic [8:0] dx_q, dx_d, dy_q, dy_d;
  logic [1:0] overflow_q, overflow_d;
  logic [3:0] dz_q, dz_d;

  assign rx_s = ps2.received_data;
  assign en_s = ps2.received_data_en;

  // State register and sequencing context
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_SEND;
      cmd_idx_q <= 4'd0;
      retry_q   <= {RW{1'b0}};
      timer_q   <= {TW{1'b0}};
      bcnt_q    <= 2'd0;
      hdr_q     <= 7'd0;
      b1_q      <= 8'd0;
`ifdef PS2_SEQ_INTELLIMOUSE_EN
      ims_q     <= 1'b0;
      b2_q      <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      bcnt_q    <= bcnt_d;
      hdr_q     <= hdr_d;
      b1_q      <= b1_d;
`ifdef PS2_SEQ_INTELLIMOUSE_EN
      ims_q     <= ims_d;
      b2_q      <= b2_d;
`endif
    end
  end

  // Next-state, command index, retry budget and packet assembly
  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    retry_d   = retry_q;
    bcnt_d    = bcnt_q;
    hdr_d     = hdr_q;
    b1_d      = b1_q;
    emit_s    = 1'b0;
    ylo_s     = rx_s;
    zw_s      = 4'd0;
`ifdef PS2_SEQ_INTELLIMOUSE_EN
    ims_d     = ims_q;
    b2_d      = b2_q;
`endif
    case (state_q)
      ST_SEND: begin
        if (ps2.error_communication_timed_out) state_d = ST_FAIL;
        else if (ps2.command_was_sent)         state_d = ST_ACK;
        else                                   state_d = ST_SEND;
      end
      ST_ACK: begin
        if (en_s) begin
          if (rx_s == 8'hFA) begin
            if (cmd_idx_q == 4'd0) begin
              state_d = ST_BAT_AA;
`ifdef PS2_SEQ_INTELLIMOUSE_EN
            end else if (cmd_idx_q == ID_IDX) begin
              state_d = ST_WAIT_ID;
`endif
            end else if (cmd_idx_q == LAST_IDX) begin
              state_d = ST_STREAM;
            end else begin
              cmd_idx_d = cmd_idx_q + 4'd1;
              state_d   = ST_SEND;
            end
          end else if (rx_s == 8'hFE) begin
            // Resend request repeats the same command but still spends a retry
            if (retry_q == RETRY_MAX) begin
              state_d = ST_ERROR;
            end else begin
              retry_d = retry_q + R_ONE;
              state_d = ST_SEND;
            end
          end else begin
            state_d = ST_FAIL;
          end
        end else if (timer_q >= RESP_TO) state_d = ST_FAIL;
        else                             state_d = ST_ACK;
      end
      ST_BAT_AA: begin
        if (en_s)                   state_d = (rx_s == 8'hAA) ? ST_BAT_ID : ST_FAIL;
        else if (timer_q >= RESP_TO) state_d = ST_FAIL;
        else                        state_d = ST_BAT_AA;
      end
      ST_BAT_ID: begin
        if (en_s && rx_s == 8'h00) begin
          cmd_idx_d = 4'd1;
          state_d   = ST_SEND;
        end else if (en_s || timer_q >= RESP_TO) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_BAT_ID;
        end
      end
`ifdef PS2_SEQ_INTELLIMOUSE_EN
      ST_WAIT_ID: begin
        if (en_s && (rx_s == 8'h03 || rx_s == 8'h00)) begin
          ims_d     = (rx_s == 8'h03);
          cmd_idx_d = LAST_IDX;
          state_d   = ST_SEND;
        end else if (en_s || timer_q >= RESP_TO) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_WAIT_ID;
        end
      end
`endif
      ST_FAIL: begin
        if (retry_q == RETRY_MAX) begin
          state_d = ST_ERROR;
        end else begin
          retry_d   = retry_q + R_ONE;
          cmd_idx_d = 4'd0;
          state_d   = ST_SEND;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      ST_STREAM: begin
        state_d = ST_STREAM;
        if (en_s) begin
          case (bcnt_q)
            2'd0: begin
              if (rx_s[3]) begin
                hdr_d  = {rx_s[7:4], rx_s[2:0]};
                bcnt_d = 2'd1;
              end else begin
                bcnt_d = 2'd0;
              end
            end
            2'd1: begin
              b1_d   = rx_s;
              bcnt_d = 2'd2;
            end
            2'd2: begin
`ifdef PS2_SEQ_INTELLIMOUSE_EN
              if (ims_q) begin
                b2_d   = rx_s;
                bcnt_d = 2'd3;
              end else begin
                emit_s = 1'b1;
                bcnt_d = 2'd0;
              end
`else
              emit_s = 1'b1;
              bcnt_d = 2'd0;
`endif
            end
            2'd3: begin
`ifdef PS2_SEQ_INTELLIMOUSE_EN
              emit_s = 1'b1;
              ylo_s  = b2_q;
              zw_s   = rx_s[3:0];
`endif
              bcnt_d = 2'd0;
            end
            default: bcnt_d = 2'd0;
          endcase
        end else if (bcnt_q != 2'd0 && timer_q >= GAP_TO) begin
          bcnt_d = 2'd0;
        end else begin
          bcnt_d = bcnt_q;
        end
      end
      default: state_d = ST_FAIL;
    endcase
  end

  // Response/gap timer: cleared on every state entry and on every streamed byte
  always_comb begin
    if (state_d != state_q || (state_q == ST_STREAM && en_s)) timer_d = {TW{1'b0}};
    else if (timer_q < T_SAT)                                timer_d = timer_q + T_ONE;
    else                                                     timer_d = timer_q;
  end

  // Output decode from the next state so send_command drops the cycle after the handshake
  always_comb begin
    if (state_d == ST_SEND) begin
      send_command_d = 1'b1;
      the_command_d  = cmd_byte(cmd_idx_d);
    end else begin
      send_command_d = 1'b0;
      the_command_d  = the_command_q;
    end
    init_done_d    = (state_d == ST_STREAM);
    init_error_d   = (state_d == ST_ERROR);
    packet_valid_d = emit_s;
    if (emit_s) begin
      buttons_d  = hdr_q[2:0];
      dx_d       = {hdr_q[3], b1_q};
      dy_d       = {hdr_q[4], ylo_s};
      overflow_d = {hdr_q[6], hdr_q[5]};
      dz_d       = zw_s;
    end else begin
      buttons_d  = buttons_q;
      dx_d       = dx_q;
      dy_d       = dy_q;
      overflow_d = overflow_q;
      dz_d       = dz_q;
    end
  end

  // Registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      the_command_q  <= 8'h00;
      send_command_q <= 1'b0;
      init_done_q    <= 1'b0;
      init_error_q   <= 1'b0;
      packet_valid_q <= 1'b0;
      buttons_q      <= 3'd0;
      dx_q           <= 9'd0;
      dy_q           <= 9'd0;
      overflow_q     <= 2'd0;
      dz_q           <= 4'd0;
    end else begin
      the_command_q  <= the_command_d;
      send_command_q <= send_command_d;
      init_done_q    <= init_done_d;
      init_error_q   <= init_error_d;
      packet_valid_q <= packet_valid_d;
      buttons_q      <= buttons_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      overflow_q     <= overflow_d;
      dz_q           <= dz_d;
    end
  end

  assign ps2.the_command  = the_command_q;
  assign ps2.send_command = send_command_q;
  assign init_done        = init_done_q;
  assign init_error       = init_error_q;
  assign packet_valid     = packet_valid_q;
  assign buttons          = buttons_q;
  assign dx               = dx_q;
  assign dy               = dy_q;
  assign overflow         = overflow_q;
  assign dz               = dz_q;
endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Bench for ps2_mouse_sequencer: behavioural mouse/transceiver model, randomized stream bytes,
// and a packet reference model built from the framing rules.
module tb_ps2_mouse_sequencer;
  localparam int RESP_TO = 1000;
  localparam int GAP_TO  = 200;
  localparam int MODE_NORMAL = 0, MODE_FE = 1, MODE_CTO = 2, MODE_SILENT = 3;

  typedef struct { int gap; logic [7:0] b; } rx_item_t;
  typedef struct { int btn; int dx; int dy; int ovf; int dz; } pkt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done, init_error, packet_valid;
  logic [2:0] buttons;
  logic [8:0] dx, dy;
  logic [1:0] overflow;
  logic [3:0] dz;

  ps2_mouse_sequencer_if bus();

  ps2_mouse_sequencer #(
    .SAMPLE_RATE(8'd100), .RESP_TIMEOUT(RESP_TO), .PKT_GAP_TIMEOUT(GAP_TO), .MAX_RETRIES(3)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .ps2(bus),
    .init_done(init_done), .init_error(init_error), .packet_valid(packet_valid),
    .buttons(buttons), .dx(dx), .dy(dy), .overflow(overflow), .dz(dz)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int dev_mode = MODE_NORMAL;
  bit fe_used = 1'b0;
  bit cto_used = 1'b0;
  logic [7:0] cmd_log[$];
  logic [7:0] exp_cmds[$];
  rx_item_t   tx_q[$];
  rx_item_t   stream[$];
  pkt_t       got_q[$];
  pkt_t       exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Device + transceiver model: accepts a held command after 3 cycles and queues the replies
  initial begin : responder
    int hi_cnt;
    logic [7:0] c;
    hi_cnt = 0;
    bus.command_was_sent = 1'b0;
    bus.error_communication_timed_out = 1'b0;
    forever begin
      @(negedge clk);
      bus.command_was_sent = 1'b0;
      bus.error_communication_timed_out = 1'b0;
      if (bus.send_command === 1'b1 && reset == 1'b0) hi_cnt++;
      else hi_cnt = 0;
      if (hi_cnt == 3) begin
        c = bus.the_command;
        cmd_log.push_back(c);
        if (dev_mode == MODE_CTO && c == 8'hF4 && !cto_used) begin
          cto_used = 1'b1;
          bus.error_communication_timed_out = 1'b1;
        end else begin
          bus.command_was_sent = 1'b1;
          if (dev_mode == MODE_FE && c == 8'hF3 && !fe_used) begin
            fe_used = 1'b1;
            tx_q.push_back('{gap: 5, b: 8'hFE});
          end else if (dev_mode != MODE_SILENT) begin
            tx_q.push_back('{gap: 5, b: 8'hFA});
            if (c == 8'hFF) begin
              tx_q.push_back('{gap: 5, b: 8'hAA});
              tx_q.push_back('{gap: 5, b: 8'h00});
            end
          end
        end
      end
    end
  end

  // Sole driver of the received-byte strobe
  initial begin : driver
    rx_item_t it;
    bus.received_data = 8'h00;
    bus.received_data_en = 1'b0;
    forever begin
      @(negedge clk);
      bus.received_data_en = 1'b0;
      if (tx_q.size() > 0) begin
        if (tx_q[0].gap > 0) begin
          tx_q[0].gap = tx_q[0].gap - 1;
        end else begin
          it = tx_q.pop_front();
          bus.received_data = it.b;
          bus.received_data_en = 1'b1;
          last_strobe_cyc = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    pkt_t p;
    if (packet_valid === 1'b1) begin
      p.btn = int'(buttons);
      p.dx  = $signed(dx);
      p.dy  = $signed(dy);
      p.ovf = int'(overflow);
      p.dz  = int'(dz);
      got_q.push_back(p);
    end
  end

  // Reference framing: sync on bit3, drop partial packets after an over-long gap
  task automatic build_expected();
    int part[$];
    pkt_t p;
    exp_q.delete();
    foreach (stream[i]) begin
      if (stream[i].gap > GAP_TO) part.delete();
      if (part.size() == 0 && stream[i].b[3] == 1'b0) continue;
      part.push_back(int'(stream[i].b));
      if (part.size() == 3) begin
        p.btn = part[0] % 8;
        p.dx  = part[1] - 256 * ((part[0] / 16) % 2);
        p.dy  = part[2] - 256 * ((part[0] / 32) % 2);
        p.ovf = part[0] / 64;
        p.dz  = 0;
        exp_q.push_back(p);
        part.delete();
      end
    end
  endtask

  function automatic pkt_t got_at(input int i);
    pkt_t p;
    p = '{btn: -1, dx: -9999, dy: -9999, ovf: -1, dz: -1};
    if (i < got_q.size()) p = got_q[i];
    return p;
  endfunction

  task automatic wait_level(input int sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((sel == 0 && init_done === 1'b1) || (sel == 1 && init_error === 1'b1) ||
          (sel == 2 && bus.send_command === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, cmd_log.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_cmds[i]);
  endtask

  task automatic restart(input int mode);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmd_log.delete();
    tx_q.delete();
    got_q.delete();
    fe_used = 1'b0;
    cto_used = 1'b0;
    dev_mode = mode;
    reset = 1'b0;
  endtask

  initial begin : main
    bit ok;
    int g, hi;
    pkt_t p;
    repeat (3) @(negedge clk);
    check("rst_send_command", bus.send_command, 0);
    check("rst_the_command", bus.the_command, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_packet_valid", packet_valid, 0);
    check("rst_buttons", buttons, 0);
    check("rst_dx", dx, 0);
    check("rst_dy", dy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dz", dz, 0);

    // Reset while a command is being requested
    reset = 1'b0;
    wait_level(2, 20, ok);
    check("first_send_seen", ok, 1);
    check("first_cmd_ff", bus.the_command, 8'hFF);
    reset = 1'b1;
    @(negedge clk);
    check("send_drop_on_reset", bus.send_command, 0);

    // Clean bring-up
    restart(MODE_NORMAL);
    wait_level(0, 3000, ok);
    check("normal_init_done", ok, 1);
    g = cyc - last_strobe_cyc;
    check("normal_init_latency", (g >= 1 && g <= 3), 1);
    check("normal_init_error", init_error, 0);
    exp_cmds = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
    check_log("normal");

    // Stream: plan vectors then random bytes
    stream.delete();
    stream.push_back('{gap: 5, b: 8'h39}); stream.push_back('{gap: 1, b: 8'h05});
    stream.push_back('{gap: 1, b: 8'hFB});
    stream.push_back('{gap: 5, b: 8'h00}); stream.push_back('{gap: 1, b: 8'h08});
    stream.push_back('{gap: 1, b: 8'h10}); stream.push_back('{gap: 1, b: 8'h20});
    stream.push_back('{gap: 5, b: 8'h08}); stream.push_back('{gap: 1, b: 8'h01});
    stream.push_back('{gap: 400, b: 8'h08}); stream.push_back('{gap: 1, b: 8'h02});
    stream.push_back('{gap: 1, b: 8'h03});
    for (int k = 0; k < 90; k++) begin
      g = ($urandom_range(0, 9) == 0) ? 400 : int'($urandom_range(1, 20));
      stream.push_back('{gap: g, b: 8'($urandom_range(0, 255))});
    end
    build_expected();
    foreach (stream[i]) tx_q.push_back(stream[i]);
    drain(30000, ok);
    check("stream_drained", ok, 1);
    p = got_at(0);
    check("plan_pkt0_buttons", p.btn, 1);
    check("plan_pkt0_dx", p.dx, -251);
    check("plan_pkt0_dy", p.dy, -5);
    check("plan_pkt0_ovf", p.ovf, 0);
    p = got_at(1);
    check("plan_pkt1_dx", p.dx, 16);
    check("plan_pkt1_dy", p.dy, 32);
    p = got_at(2);
    check("plan_pkt2_dx", p.dx, 2);
    check("plan_pkt2_dy", p.dy, 3);
    check("pkt_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      p = got_at(i);
      check($sformatf("pkt%0d_btn", i), p.btn, exp_q[i].btn);
      check($sformatf("pkt%0d_dx", i), p.dx, exp_q[i].dx);
      check($sformatf("pkt%0d_dy", i), p.dy, exp_q[i].dy);
      check($sformatf("pkt%0d_ovf", i), p.ovf, exp_q[i].ovf);
      check($sformatf("pkt%0d_dz", i), p.dz, exp_q[i].dz);
    end

    // One resend request on F3
    restart(MODE_FE);
    wait_level(0, 3000, ok);
    check("fe_init_done", ok, 1);
    exp_cmds = '{8'hFF, 8'hF3, 8'hF3, 8'h64, 8'hF4};
    check_log("fe");

    // Transmission failure on F4 forces a full restart
    restart(MODE_CTO);
    wait_level(0, 3000, ok);
    check("cto_init_done", ok, 1);
    exp_cmds = '{8'hFF, 8'hF3, 8'h64, 8'hF4, 8'hFF, 8'hF3, 8'h64, 8'hF4};
    check_log("cto");

    // Silent device: retries exhausted, sticky error
    restart(MODE_SILENT);
    wait_level(1, 10000, ok);
    check("silent_init_error", ok, 1);
    exp_cmds = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tx_q.push_back('{gap: 3, b: 8'h08});
    tx_q.push_back('{gap: 1, b: 8'h01});
    tx_q.push_back('{gap: 1, b: 8'h02});
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.send_command !== 1'b0) hi++;
    end
    check("silent_send_low", hi, 0);
    check("silent_error_sticky", init_error, 1);
    check("silent_init_done", init_done, 0);
    check("silent_no_packets", got_q.size(), 0);
    check_log("silent");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
